// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and load/store.
// Optional build macro MEM_PORT_ARB_ROUND_ROBIN_EN swaps fixed data priority for alternating grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset_n,
    input  logic              IF_req,
    input  logic [ADDR_W-1:0] IF_address,
    output logic              IF_done,
    output logic [DATA_W-1:0] IF_rdata,
    input  logic              D_req,
    input  logic              D_write,
    input  logic [1:0]        D_length,
    input  logic              D_signed,
    input  logic [ADDR_W-1:0] D_address,
    input  logic [DATA_W-1:0] D_wdata,
    output logic              D_done,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_misaligned,
    output logic              MEM_valid,
    output logic              MEM_write,
    output logic [1:0]        MEM_length,
    output logic              MEM_signed,
    output logic [ADDR_W-1:0] MEM_address,
    output logic [DATA_W-1:0] MEM_wdata,
    input  logic              MEM_ready,
    input  logic [DATA_W-1:0] MEM_rdata,
    output logic              ARB_busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_DATA     = 2'd2,
        ST_COMPLETE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              skip_q, skip_d;
    logic              bad_q, bad_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_write_q, mem_write_d;
    logic [1:0]        mem_length_q, mem_length_d;
    logic              mem_signed_q, mem_signed_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_mis_q, d_mis_d;
    logic              busy_q, busy_d;
    logic              data_wins;
    logic              d_bad;

`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    logic last_fetch_q, last_fetch_d;
`else
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q, starve_d;
`endif

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q       <= ST_IDLE;
            skip_q        <= 1'b0;
            bad_q         <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_length_q  <= 2'b00;
            mem_signed_q  <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            if_done_q     <= 1'b0;
            if_rdata_q    <= '0;
            d_done_q      <= 1'b0;
            d_rdata_q     <= '0;
            d_mis_q       <= 1'b0;
            busy_q        <= 1'b0;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
            last_fetch_q  <= 1'b1;
`else
            starve_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            bad_q         <= bad_d;
            mem_valid_q   <= mem_valid_d;
            mem_write_q   <= mem_write_d;
            mem_length_q  <= mem_length_d;
            mem_signed_q  <= mem_signed_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            if_done_q     <= if_done_d;
            if_rdata_q    <= if_rdata_d;
            d_done_q      <= d_done_d;
            d_rdata_q     <= d_rdata_d;
            d_mis_q       <= d_mis_d;
            busy_q        <= busy_d;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
            last_fetch_q  <= last_fetch_d;
`else
            starve_q      <= starve_d;
`endif
        end
    end

    // Next state, request latching and done/data capture.
    always_comb begin
        state_d       = state_q;
        skip_d        = skip_q;
        bad_d         = bad_q;
        mem_valid_d   = mem_valid_q;
        mem_write_d   = mem_write_q;
        mem_length_d  = mem_length_q;
        mem_signed_d  = mem_signed_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        if_done_d     = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_done_d      = 1'b0;
        d_rdata_d     = d_rdata_q;
        d_mis_d       = 1'b0;
        d_bad         = ((D_length == 2'b10) && D_address[0]) ||
                        ((D_length == 2'b11) && (D_address[1:0] != 2'b00));
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
        last_fetch_d  = last_fetch_q;
        data_wins     = D_req && (!IF_req || last_fetch_q);
`else
        starve_d      = starve_q;
        data_wins     = D_req && (!IF_req || (starve_q < CNT_W'(STARVE_LIMIT)));
`endif

        case (state_q)
            ST_IDLE: begin
                if (data_wins) begin
                    state_d       = ST_DATA;
                    skip_d        = (D_length == 2'b00) || d_bad;
                    bad_d         = d_bad;
                    mem_valid_d   = !((D_length == 2'b00) || d_bad);
                    mem_write_d   = D_write;
                    mem_length_d  = D_length;
                    mem_signed_d  = D_signed;
                    mem_address_d = D_address;
                    mem_wdata_d   = D_wdata;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
                    last_fetch_d  = 1'b0;
`endif
                end else if (IF_req) begin
                    state_d       = ST_FETCH;
                    skip_d        = 1'b0;
                    bad_d         = 1'b0;
                    mem_valid_d   = 1'b1;
                    mem_write_d   = 1'b0;
                    mem_length_d  = 2'b11;
                    mem_signed_d  = 1'b0;
                    mem_address_d = IF_address;
                    mem_wdata_d   = '0;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
                    last_fetch_d  = 1'b1;
`endif
                end
`ifndef MEM_PORT_ARB_ROUND_ROBIN_EN
                // Count data grants that bypass a waiting fetch, saturating at the limit.
                if (!IF_req || !data_wins) begin
                    starve_d = '0;
                end else if (starve_q < CNT_W'(STARVE_LIMIT)) begin
                    starve_d = starve_q + CNT_W'(1);
                end
`endif
            end
            ST_FETCH: begin
                if (MEM_ready) begin
                    state_d     = ST_COMPLETE;
                    mem_valid_d = 1'b0;
                    if_rdata_d  = MEM_rdata;
                    if_done_d   = 1'b1;
                end
            end
            ST_DATA: begin
                if (skip_q) begin
                    state_d  = ST_COMPLETE;
                    d_done_d = 1'b1;
                    d_mis_d  = bad_q;
                end else if (MEM_ready) begin
                    state_d     = ST_COMPLETE;
                    mem_valid_d = 1'b0;
                    d_done_d    = 1'b1;
                    if (!mem_write_q) begin
                        d_rdata_d = MEM_rdata;
                    end
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign IF_done      = if_done_q;
    assign IF_rdata     = if_rdata_q;
    assign D_done       = d_done_q;
    assign D_rdata      = d_rdata_q;
    assign D_misaligned = d_mis_q;
    assign MEM_valid    = mem_valid_q;
    assign MEM_write    = mem_write_q;
    assign MEM_length   = mem_length_q;
    assign MEM_signed   = mem_signed_q;
    assign MEM_address  = mem_address_q;
    assign MEM_wdata    = mem_wdata_q;
    assign ARB_busy     = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester of the RISC-V datapath.
- Latches each request, runs a valid/ready handshake on the memory side, and returns read data with a one-cycle done pulse.
- Data accesses have priority, protected by a fetch-starvation guard.
- Sits between the CPU top level and the unified memory; ARB_busy feeds the PC-stall logic.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 4, consecutive data grants allowed while IF_req is pending before fetch is forced.

Ports:
- SYS_clk  input  1  system clock, rising edge.
- SYS_reset_n  input  1  asynchronous active-low reset.
- IF_req  input  1  fetch request; held high until IF_done.
- IF_address  input  ADDR_W  fetch address, word-aligned.
- IF_done  output  1  one-cycle pulse; IF_rdata valid.
- IF_rdata  output  DATA_W  fetched word; holds until next fetch completion.
- D_req  input  1  data request; held high until D_done.
- D_write  input  1  1 = store, 0 = load.
- D_length  input  2  01 byte, 10 half, 11 word, 00 no-op.
- D_signed  input  1  sign-extend load result.
- D_address  input  ADDR_W  data address.
- D_wdata  input  DATA_W  store data.
- D_done  output  1  one-cycle completion pulse.
- D_rdata  output  DATA_W  load result; holds until next load completion.
- D_misaligned  output  1  qualifies D_done: access rejected, no memory access performed.
- MEM_valid  output  1  memory request valid.
- MEM_write  output  1  store strobe.
- MEM_length  output  2  access length.
- MEM_signed  output  1  load sign control.
- MEM_address  output  ADDR_W  memory address.
- MEM_wdata  output  DATA_W  store data to memory.
- MEM_ready  input  1  memory accepts / completes this cycle; MEM_rdata valid.
- MEM_rdata  input  DATA_W  load data from memory.
- ARB_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: async on SYS_reset_n low.
  - State goes to IDLE; all outputs and the starve counter go to 0.
  - MEM_valid drops immediately, even mid-access. The in-flight transaction is discarded and no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, FETCH, DATA, COMPLETE.
- IDLE arbitration, evaluated each cycle:
  - D_req and (not IF_req or starve_cnt < STARVE_LIMIT): go to DATA.
  - Else if IF_req: go to FETCH.
  - Request fields are latched on the transition; later input changes are ignored until done.
- DATA entry checks:
  - D_length == 00: no memory access; go directly to COMPLETE with D_done.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): no memory access; go to COMPLETE with D_done=1 and D_misaligned=1.
- FETCH / DATA access:
  - MEM_valid=1 with latched fields. Fetch uses MEM_length=11, MEM_write=0, MEM_signed=0.
  - MEM_valid is held until a cycle with MEM_ready=1. In that cycle, MEM_rdata is captured (loads and fetches only) and the FSM goes to COMPLETE.
  - MEM_ready while MEM_valid=0 is ignored.
- COMPLETE: lasts one cycle. The done pulse for the granted requester is high. No arbitration this cycle (the requester drops or renews req). Next state is IDLE.
- Minimum latency: req sampled in IDLE at cycle 0, MEM_valid at cycle 1, done at cycle 2 with zero-wait memory.
- Starve counter:
  - Increments on each DATA grant made while IF_req=1.
  - Clears on any FETCH grant, or whenever IF_req=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- D_misaligned is 0 in every cycle except a misaligned completion.
- Simultaneous IF_req and D_req with starve_cnt < limit: DATA wins.

Optional Feature:
- Macro: MEM_PORT_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are pending in IDLE, the grant alternates, going to whichever requester was not granted last (reset value: "last = fetch", so data wins first). The starve counter is not implemented and STARVE_LIMIT is ignored.
- Undefined: fixed data priority with the starvation guard, as above.

Test Plan:
- Single fetch: IF_req=1, IF_address=0x100, MEM_ready=1 tied, MEM_rdata=0x00500093 -> MEM_valid high at cycle 1 with MEM_address=0x100 and MEM_length=11; IF_done pulses at cycle 2 with IF_rdata=0x00500093.
- Store with 3 wait states: D_req, D_write=1, D_length=10, D_address=0x202, D_wdata=0xBEEF -> MEM_valid held 4 cycles with stable fields; D_done exactly 1 cycle after MEM_ready; D_misaligned=0.
- Misaligned word load: D_length=11, D_address=0x203 -> MEM_valid never asserted; D_done=1 and D_misaligned=1 at cycle 2.
- Contention, STARVE_LIMIT=4: IF_req and D_req held high continuously -> grant order D, D, D, D, F, D...; with ROUND_ROBIN_EN defined -> D, F, D, F.
- Reset mid-access: assert SYS_reset_n=0 while MEM_valid=1 and MEM_ready=0 -> MEM_valid=0 immediately; after release, state is IDLE, no done pulse, and the next request completes normally.
- No-op data: D_length=00 -> D_done at cycle 2, no MEM_valid, D_rdata unchanged.
